// File: rtl/mram_spi_slave.sv
// SPI-slave (mode 3) model of the serial MRAM: opcode/address decode, byte-wide
// memory, streaming READ/WRITE. Optional RDSR status read under MRAM_SLAVE_RDSR_EN.
module mram_spi_slave #(
  parameter int ADDRESSBITS = 16,
  parameter int MEMBYTES    = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic spiCs_i,
  input  logic spiClk_i,
  input  logic spiMosi_i,
  output logic spiMiso_o,
  output logic wel_o
);
  localparam int PW = $clog2(MEMBYTES);
  localparam int CW = (ADDRESSBITS > 8) ? $clog2(ADDRESSBITS) : 3;

  typedef enum logic [2:0] {IDLE, CMD, ADDR, RDATA, WDATA, STATUS, IGNORE} state_t;

  state_t                 state;
  logic [1:0]             csSync, mosiSync;
  logic [2:0]             sckSync;
  logic                   csS, mosiS, sckRise, sckFall;
  logic [CW-1:0]          cnt;
  logic [7:0]             shiftSr;
  logic [ADDRESSBITS-1:0] addrSr;
  logic [PW-1:0]          ptr, wrIdx;
  logic [7:0]             wrByte, rdByte, loadByte, inByte;
  logic [ADDRESSBITS-1:0] addrNext;
  logic                   wrPend, isRead, armed, wel, shiftOut;
  logic [7:0]             mem [MEMBYTES];

  // Synchronizers are not reset so a reset pulse cannot fake a CS-high level.
  always_ff @(posedge clk_i) begin
    csSync   <= {csSync[0], spiCs_i};
    mosiSync <= {mosiSync[0], spiMosi_i};
    sckSync  <= {sckSync[1:0], spiClk_i};
  end

  assign csS      = csSync[1];
  assign mosiS    = mosiSync[1];
  assign sckRise  = sckSync[1] & ~sckSync[2];
  assign sckFall  = ~sckSync[1] & sckSync[2];
  assign inByte   = {shiftSr[6:0], mosiS};
  assign addrNext = {addrSr[ADDRESSBITS-2:0], mosiS};
  assign rdByte   = mem[ptr];
  assign wel_o    = wel;

`ifdef MRAM_SLAVE_RDSR_EN
  assign shiftOut = (state == RDATA) || (state == STATUS);
  assign loadByte = (state == STATUS) ? {6'b0, wel, 1'b0} : rdByte;
`else
  assign shiftOut = (state == RDATA);
  assign loadByte = rdByte;
`endif

  always_ff @(posedge clk_i) begin
    if (wrPend) mem[wrIdx] <= wrByte;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      wel       <= 1'b0;
      spiMiso_o <= 1'b0;
      ptr       <= '0;
      cnt       <= '0;
      shiftSr   <= '0;
      addrSr    <= '0;
      isRead    <= 1'b0;
      armed     <= 1'b0;
      wrPend    <= 1'b0;
    end else begin
      wrPend <= 1'b0;
      // Handled ahead of the CS check so an 8th bit coinciding with CS rise still writes.
      if (state == WDATA && sckRise) begin
        shiftSr <= inByte;
        cnt     <= cnt + 1'b1;
        if (cnt[2:0] == 3'd7) begin
          wrPend <= wel;
          wrByte <= inByte;
          wrIdx  <= ptr;
          ptr    <= ptr + 1'b1;
        end
      end
      if (shiftOut && sckFall) begin
        cnt <= cnt + 1'b1;
        if (cnt[2:0] == 3'd0) begin
          spiMiso_o <= loadByte[7];
          shiftSr   <= {loadByte[6:0], 1'b0};
        end else begin
          spiMiso_o <= shiftSr[7];
          shiftSr   <= {shiftSr[6:0], 1'b0};
        end
        if (state == RDATA && cnt[2:0] == 3'd7) ptr <= ptr + 1'b1;
      end
      if (csS) begin
        state     <= IDLE;
        cnt       <= '0;
        spiMiso_o <= 1'b0;
        armed     <= 1'b1;
        if (state == WDATA) wel <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            spiMiso_o <= 1'b0;
            if (armed) state <= CMD;
          end
          CMD: if (sckRise) begin
            shiftSr <= inByte;
            cnt     <= cnt + 1'b1;
            if (cnt[2:0] == 3'd7) begin
              cnt <= '0;
              case (inByte)
                8'h06: begin wel <= 1'b1; state <= IGNORE; end
                8'h04: begin wel <= 1'b0; state <= IGNORE; end
                8'h03: begin isRead <= 1'b1; state <= ADDR; end
                8'h02: begin isRead <= 1'b0; state <= ADDR; end
`ifdef MRAM_SLAVE_RDSR_EN
                8'h05: state <= STATUS;
`endif
                default: state <= IGNORE;
              endcase
            end
          end
          ADDR: if (sckRise) begin
            addrSr <= addrNext;
            cnt    <= cnt + 1'b1;
            if (cnt == CW'(ADDRESSBITS - 1)) begin
              cnt   <= '0;
              ptr   <= addrNext[PW-1:0];
              state <= isRead ? RDATA : WDATA;
            end
          end
          IGNORE: spiMiso_o <= 1'b0;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mram_spi_slave.sv
// Directed bench for mram_spi_slave: table of SPI transactions plus a reset-abort sequence.
module tb_mram_spi_slave;
  localparam int HALF = 6;
`ifdef MRAM_SLAVE_RDSR_EN
  localparam logic [31:0] RDSR_EXP = 32'h0000_0202;
`else
  localparam logic [31:0] RDSR_EXP = 32'h0000_0000;
`endif

  logic clk = 1'b0;
  logic rst, cs, sck, mosi, miso, wel;
  int   nTests = 0;
  int   nFail  = 0;

  typedef struct {
    logic [7:0]  op;
    logic [15:0] addr;
    int          n;
    logic [31:0] data;
    logic [31:0] exp;
    logic        expWel;
  } vec_t;

  vec_t vecs[19];

  always #5 clk = ~clk;

  mram_spi_slave #(.ADDRESSBITS(16), .MEMBYTES(1024)) dut (
    .clk_i(clk), .rst_i(rst), .spiCs_i(cs), .spiClk_i(sck),
    .spiMosi_i(mosi), .spiMiso_o(miso), .wel_o(wel)
  );

  task automatic waitClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic sendBit(input logic b, output logic r);
    sck  = 1'b0;
    mosi = b;
    waitClk(HALF);
    r   = miso;
    sck = 1'b1;
    waitClk(HALF);
  endtask

  task automatic sendByte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) sendBit(tx[i], rx[i]);
  endtask

  task automatic csLow();
    cs = 1'b0;
    waitClk(HALF);
  endtask

  task automatic csHigh();
    waitClk(2);
    cs = 1'b1;
    waitClk(10);
  endtask

  task automatic doXfer(input vec_t v, output logic [31:0] rx);
    logic [7:0]  b;
    logic [31:0] d;
    rx = '0;
    d  = v.data;
    csLow();
    sendByte(v.op, b);
    if (v.op == 8'h02 || v.op == 8'h03) begin
      sendByte(v.addr[15:8], b);
      sendByte(v.addr[7:0], b);
    end
    for (int k = 0; k < v.n; k++) begin
      sendByte((v.op == 8'h02) ? d[(v.n-1-k)*8 +: 8] : 8'h00, b);
      rx = {rx[23:0], b};
    end
    csHigh();
  endtask

  initial begin
    logic [31:0] rx;
    logic        r;
    logic [7:0]  b;
    vecs[0]  = '{8'h06, 16'h0000, 0, 32'h0, 32'h0, 1'b1};
    vecs[1]  = '{8'h02, 16'h0020, 1, 32'h00, 32'h0, 1'b0};
    vecs[2]  = '{8'h02, 16'h0020, 1, 32'h55, 32'h0, 1'b0};
    vecs[3]  = '{8'h03, 16'h0020, 1, 32'h0, 32'h00, 1'b0};
    vecs[4]  = '{8'h06, 16'h0000, 0, 32'h0, 32'h0, 1'b1};
    vecs[5]  = '{8'h02, 16'h0010, 4, 32'hDEADBEEF, 32'h0, 1'b0};
    vecs[6]  = '{8'h03, 16'h0010, 4, 32'h0, 32'hDEADBEEF, 1'b0};
    vecs[7]  = '{8'h03, 16'h0011, 3, 32'h0, 32'h00ADBEEF, 1'b0};
    vecs[8]  = '{8'h06, 16'h0000, 0, 32'h0, 32'h0, 1'b1};
    vecs[9]  = '{8'h02, 16'h03FF, 2, 32'h1122, 32'h0, 1'b0};
    vecs[10] = '{8'h03, 16'h03FF, 2, 32'h0, 32'h1122, 1'b0};
    vecs[11] = '{8'h03, 16'h0000, 1, 32'h0, 32'h22, 1'b0};
    vecs[12] = '{8'h03, 16'h07FF, 1, 32'h0, 32'h11, 1'b0};
    vecs[13] = '{8'h06, 16'h0000, 0, 32'h0, 32'h0, 1'b1};
    vecs[14] = '{8'h05, 16'h0000, 2, 32'h0, RDSR_EXP, 1'b1};
    vecs[15] = '{8'h9F, 16'h0000, 1, 32'h0, 32'h0, 1'b1};
    vecs[16] = '{8'h04, 16'h0000, 0, 32'h0, 32'h0, 1'b0};
    vecs[17] = '{8'h06, 16'h0000, 0, 32'h0, 32'h0, 1'b1};
    vecs[18] = '{8'h02, 16'h0030, 1, 32'h3C, 32'h0, 1'b0};

    rst = 1'b1; cs = 1'b1; sck = 1'b1; mosi = 1'b0;
    waitClk(5);
    rst = 1'b0;
    waitClk(5);
    check("reset_wel", {31'b0, wel}, 32'h0);
    check("reset_miso", {31'b0, miso}, 32'h0);

    for (int i = 0; i < 19; i++) begin
      doXfer(vecs[i], rx);
      check($sformatf("vec%0d_wel", i), {31'b0, wel}, {31'b0, vecs[i].expWel});
      check($sformatf("vec%0d_miso_idle", i), {31'b0, miso}, 32'h0);
      if (vecs[i].n > 0 && vecs[i].op != 8'h02)
        check($sformatf("vec%0d_rdata", i), rx, vecs[i].exp);
    end

    // Reset pulsed in the 5th bit of the first write byte aborts the write and clears wel.
    doXfer(vecs[17], rx);
    check("abort_pre_wel", {31'b0, wel}, 32'h1);
    csLow();
    sendByte(8'h02, b);
    sendByte(8'h00, b);
    sendByte(8'h30, b);
    for (int i = 7; i >= 4; i--) sendBit(1'b1, r);
    sck = 1'b0; mosi = 1'b0;
    waitClk(2);
    rst = 1'b1;
    waitClk(2);
    rst = 1'b0;
    waitClk(HALF);
    sck = 1'b1;
    waitClk(HALF);
    for (int i = 2; i >= 0; i--) sendBit(1'b0, r);
    check("abort_wel_cs_low", {31'b0, wel}, 32'h0);
    csHigh();
    check("abort_wel", {31'b0, wel}, 32'h0);
    doXfer('{8'h03, 16'h0030, 1, 32'h0, 32'h3C, 1'b0}, rx);
    check("abort_read", rx, 32'h3C);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule

// File: doc/mram_spi_slave.md
# mram_spi_slave

SPI-slave model of the serial MRAM device that the `mram` bridge talks to. It is the other end of the same four-wire link: it decodes the 8-bit opcode, the address and the data bytes from MOSI, holds a byte-wide internal memory, and shifts read data back on MISO. It sits in the SoC top level or testbench in place of the external MRAM chip, so the `mram` bridge can be exercised on FPGA and in simulation without real silicon.

## Interface
- ADDRESSBITS, 16, width of the address field following READ/WRITE opcodes; must match the bridge.
- MEMBYTES, 1024, internal memory size in bytes; power of two; address index = address mod MEMBYTES.
- clk_i  in  1  system clock; all logic samples on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- spiCs_i  in  1  chip select, active-low.
- spiClk_i  in  1  SPI clock; idles high (mode 3).
- spiMosi_i  in  1  serial data from master, MSB first.
- spiMiso_o  out  1  serial data to master, MSB first.
- wel_o  out  1  write-enable latch state, for observation.

## Operation
- spiCs_i, spiClk_i, spiMosi_i each pass through a 2-FF synchronizer; a third SCK stage gives rise/fall edge strobes. All decoding uses synchronized signals only.
- SPI mode 3: MOSI sampled on SCK rising edge; spiMiso_o changes only after SCK falling edges.
- Synchronized CS high forces state IDLE, clears bit/byte counters, drops any partial byte, spiMiso_o = 0.
- States: IDLE -> CMD on CS low. CMD collects 8 bits, then:
  - 0x06 WREN: wel = 1, -> IGNORE.
  - 0x04 WRDI: wel = 0, -> IGNORE.
  - 0x03 READ, 0x02 WRITE: -> ADDR.
  - 0x05 RDSR (only with macro): -> STATUS.
  - anything else: -> IGNORE.
- ADDR collects ADDRESSBITS bits MSB first into the address pointer, then -> RDATA (READ) or WDATA (WRITE).
- RDATA: byte mem[ptr] loaded into MISO shift register; shifted out one bit per SCK falling edge; after every 8th bit ptr increments and the next byte loads. Streams until CS high.
- WDATA: every 8 complete bits, if wel = 1, write byte to mem[ptr]; ptr increments regardless of wel. Incomplete final byte discarded.
- ptr wraps from MEMBYTES-1 to 0 (index = low log2(MEMBYTES) bits; upper address bits ignored).
- wel cleared on CS rising edge that ends a WRITE command (entered WDATA), whether or not bytes were written.
- IGNORE: MOSI ignored, spiMiso_o = 0, until CS high.
- Memory content is not reset; only control state is.

## Timing
- Reset: state IDLE, wel_o = 0, spiMiso_o = 0, ptr = 0, counters 0.
- Reset asserted mid-transaction aborts it within one cycle; no memory write occurs for the byte in progress; after release the block waits for CS high before accepting a new command.
- Synchronizer latency: 2 clk_i cycles pin to synchronized level; edge strobe 1 cycle later.
- spiMiso_o updated at most 3 clk_i cycles after the SCK falling edge at the pin. Required: SCK half-period ≥ 4 clk_i cycles (bridge SPISPED ≥ 3).
- First read data bit (bit 7 of mem[address]) is on spiMiso_o after the SCK falling edge following the last address bit; memory read completes within that half-period.
- A memory write occurs 1 cycle after the rising-edge strobe that completes a byte.
- Simultaneous CS rise and 8th-bit completion: the synchronized 8th rising edge is processed first, so the byte is written.

## Configuration
- MRAM_SLAVE_RDSR_EN defined: 0x05 enters STATUS; status byte {6'b0, wel, 1'b0} shifted out repeatedly until CS high.
- Not defined: 0x05 treated as unknown opcode (IGNORE, spiMiso_o = 0); no status logic synthesized.

## Test plan
- WREN, then WRITE addr 0x0010 data 0xDE 0xAD 0xBE 0xEF; READ addr 0x0010 32 bits -> MISO returns 0xDEADBEEF; wel_o 1 after WREN, 0 after write CS rise.
- WRITE to 0x0020 with data 0x55 without preceding WREN -> READ 0x0020 returns prior content (0x00 after an initializing write of 0x00); wel_o stays 0.
- WREN, WRITE at MEMBYTES-1 (0x03FF) bytes 0x11 0x22 -> mem[0x3FF] = 0x11, mem[0x000] = 0x22; READ 0x03FF 16 bits -> 0x1122.
- Through the `mram` bridge (SPISPED = 3): Wishbone sel 0b0100 write of 0x00AB0000 to word 4 then full-word read -> byte 2 = 0xAB, other bytes unchanged.
- rst_i pulsed during 5th bit of first WDATA byte -> byte not written, wel_o = 0, next READ command after CS toggle works normally.
- With MRAM_SLAVE_RDSR_EN: WREN then RDSR 16 bits -> MISO 0x02 0x02; without macro -> MISO 0x00 0x00.
